// File: rtl/mem_link_arbiter.sv
// Arbitrates the fetch and data ports onto one UART byte link, serialising requests and reassembling replies.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise the data port has fixed priority.
module mem_link_arbiter #(
    parameter int         ADDR_W  = 32,
    parameter logic [1:0] IF_MASK = 2'd3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [1:0]        mem_len,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              busy
);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_WDATA, S_RECV, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [1:0]        mask_q, mask_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              win_mem_q, win_mem_d;
    logic [31:0]       rbuf_q, rbuf_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic              pick_mem;

    logic [7:0] hdr_byte [7];
    logic [7:0] wr_byte  [5];

    // Link bytes carry 7 payload bits; the stripped MSBs travel in a trailing byte.
    assign hdr_byte[0] = we_q ? 8'h80 : 8'hC0;
    assign hdr_byte[5] = {4'b0, addr_q[31], addr_q[23], addr_q[15], addr_q[7]};
    assign hdr_byte[6] = {6'b0, mask_q};
    assign wr_byte[4]  = {4'b0, wdata_q[31], wdata_q[23], wdata_q[15], wdata_q[7]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
            assign hdr_byte[gi+1] = {1'b0, addr_q[8*gi +: 7]};
            assign wr_byte[gi]    = {1'b0, wdata_q[8*gi +: 7]};
        end
    endgenerate

`ifdef MEM_ARB_RR_EN
    logic prio_mem_q, prio_mem_d;
    assign pick_mem = mem_req & (~if_req | prio_mem_q);
`else
    assign pick_mem = mem_req;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        we_d        = we_q;
        mask_d      = mask_q;
        wdata_d     = wdata_q;
        win_mem_d   = win_mem_q;
        rbuf_d      = rbuf_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
`ifdef MEM_ARB_RR_EN
        prio_mem_d  = prio_mem_q;
`endif
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        rx_ready    = 1'b0;
        if_done     = 1'b0;
        mem_done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (if_req | mem_req) begin
                    win_mem_d = pick_mem;
                    addr_d    = pick_mem ? mem_addr : if_addr;
                    we_d      = pick_mem & mem_we;
                    mask_d    = pick_mem ? mem_len : IF_MASK;
                    wdata_d   = mem_wdata;
                    rbuf_d    = 32'h0;
                    cnt_d     = 3'd0;
                    state_d   = S_HDR;
`ifdef MEM_ARB_RR_EN
                    prio_mem_d = ~pick_mem;
`endif
                end
            end
            S_HDR: begin
                tx_valid = 1'b1;
                tx_data  = hdr_byte[cnt_q];
                if (tx_ready) begin
                    if (cnt_q == 3'd6) begin
                        cnt_d   = 3'd0;
                        state_d = we_q ? S_WDATA : S_RECV;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            S_WDATA: begin
                tx_valid = 1'b1;
                tx_data  = (cnt_q <= {1'b0, mask_q}) ? wr_byte[cnt_q[1:0]] : wr_byte[4];
                if (tx_ready) begin
                    if (cnt_q == {1'b0, mask_q} + 3'd1) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            S_RECV: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    rbuf_d[8*cnt_q[1:0] +: 8] = rx_data;
                    if (cnt_q[1:0] == mask_q) begin
                        if (win_mem_q) mem_rdata_d = rbuf_d;
                        else           if_rdata_d  = rbuf_d;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            S_DONE: begin
                mem_done = win_mem_q;
                if_done  = ~win_mem_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            mask_q      <= 2'd0;
            wdata_q     <= 32'h0;
            win_mem_q   <= 1'b0;
            rbuf_q      <= 32'h0;
            if_rdata_q  <= 32'h0;
            mem_rdata_q <= 32'h0;
`ifdef MEM_ARB_RR_EN
            prio_mem_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            mask_q      <= mask_d;
            wdata_q     <= wdata_d;
            win_mem_q   <= win_mem_d;
            rbuf_q      <= rbuf_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
`ifdef MEM_ARB_RR_EN
            prio_mem_q  <= prio_mem_d;
`endif
        end
    end

    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_link_arbiter.sv
// Randomised self-checking bench for mem_link_arbiter with a transaction-level link model.
module tb_mem_link_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
    logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
    logic [1:0]  mem_len = '0;
    logic        if_done, mem_done, tx_valid, rx_ready, busy;
    logic [31:0] if_rdata, mem_rdata;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0, rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_if = '0, exp_mem = '0;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    mem_link_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_len(mem_len), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .busy(busy)
    );

    // Expected link byte stream for one request.
    task automatic build_exp(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] len);
        exp_q.delete();
        exp_q.push_back(we ? 8'h80 : 8'hC0);
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, a[8*i +: 7]});
        exp_q.push_back({4'b0, a[31], a[23], a[15], a[7]});
        exp_q.push_back({6'b0, len});
        if (we) begin
            for (int i = 0; i <= int'(len); i++) exp_q.push_back({1'b0, wd[8*i +: 7]});
            exp_q.push_back({4'b0, wd[31], wd[23], wd[15], wd[7]});
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; if_req = 1'b0; mem_req = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_if = '0; exp_mem = '0;
    endtask

    task automatic do_txn(input bit is_mem, input bit we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] len, input logic [31:0] rxw, input bit rnd, input string name);
        logic [7:0] got[$];
        logic [7:0] last_data = '0;
        logic [31:0] val;
        bit eff_we, done_seen = 0, bad = 0, last_stall = 0, ok, tr, rv;
        logic [1:0] eff_len;
        int cyc, rxi = 0, exp_cyc;
        eff_we  = is_mem & we;
        eff_len = is_mem ? len : 2'd3;
        build_exp(eff_we, a, wd, eff_len);
        @(negedge clk);
        if (is_mem) begin
            mem_addr = a; mem_wdata = wd; mem_len = len; mem_we = we; mem_req = 1'b1; if_req = 1'b0;
        end else begin
            if_addr = a; if_req = 1'b1; mem_req = 1'b0;
        end
        tx_ready = 1'b1; rx_valid = 1'b0;
        cyc = 1;
        while (!done_seen && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (cyc == 3) begin
                if_addr = $urandom; mem_addr = $urandom; mem_wdata = $urandom;
                mem_len = 2'($urandom); mem_we = 1'($urandom);
            end
            if (last_stall && (tx_valid !== 1'b1 || tx_data !== last_data)) bad = 1;
            if (eff_we && rx_ready) bad = 1;
            if (tx_valid && rx_ready) bad = 1;
            if (is_mem ? if_done : mem_done) bad = 1;
            if (is_mem ? mem_done : if_done) begin
                done_seen = 1;
                if_req = 1'b0; mem_req = 1'b0;
            end else begin
                tr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                tx_ready = tr;
                if (tx_valid && tr) got.push_back(tx_data);
                last_stall = tx_valid && !tr;
                last_data  = tx_data;
                if (eff_we) begin
                    rx_valid = 1'b1; rx_data = 8'hEE;
                end else if (rxi <= int'(eff_len)) begin
                    rv = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                    rx_valid = rv; rx_data = rxw[8*rxi +: 8];
                    if (rx_ready && rv) rxi++;
                end else begin
                    rx_valid = 1'b0;
                end
            end
        end
        tx_ready = 1'b0; rx_valid = 1'b0; if_req = 1'b0; mem_req = 1'b0;
        $display("txn %s port=%s we=%0d addr=%h len=%0d cycles=%0d bytes=%0d",
                 name, is_mem ? "mem" : "if", eff_we, a, eff_len, cyc, got.size());
        checks++;
        if (!done_seen) begin errors++; $display("FAIL %s done_timeout got=0 want=1", name); end
        ok = (got.size() == exp_q.size());
        for (int i = 0; i < got.size() && ok; i++) if (got[i] !== exp_q[i]) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s tx_stream got=%p want=%p", name, got, exp_q);
        end
        if (!rnd) begin
            exp_cyc = 1 + 7 + (eff_we ? int'(eff_len) + 2 : int'(eff_len) + 1) + 1;
            checks++;
            if (cyc !== exp_cyc) begin errors++; $display("FAIL %s latency got=%0d want=%0d", name, cyc, exp_cyc); end
        end
        if (!eff_we) begin
            val = '0;
            for (int i = 0; i <= int'(eff_len); i++) val[8*i +: 8] = rxw[8*i +: 8];
            if (is_mem) exp_mem = val; else exp_if = val;
        end
        checks++;
        if (if_rdata !== exp_if) begin errors++; $display("FAIL %s if_rdata got=%h want=%h", name, if_rdata, exp_if); end
        checks++;
        if (mem_rdata !== exp_mem) begin errors++; $display("FAIL %s mem_rdata got=%h want=%h", name, mem_rdata, exp_mem); end
        checks++;
        if (bad) begin errors++; $display("FAIL %s handshake got=violation want=clean", name); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || if_done !== 1'b0 || mem_done !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after got=busy%b/ifd%b/memd%b want=000", name, busy, if_done, mem_done);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({tx_valid, rx_ready, busy, if_done, mem_done} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got=%b want=00000", {tx_valid, rx_ready, busy, if_done, mem_done});
        end
        checks++;
        if (if_rdata !== 32'h0 || mem_rdata !== 32'h0 || tx_data !== 8'h0) begin
            errors++; $display("FAIL reset_data got=%h/%h/%h want=0", if_rdata, mem_rdata, tx_data);
        end
    endtask

    task automatic test_directed();
        do_txn(0, 0, 32'h0000_1234, 32'h0, 2'd0, 32'h1234_5678, 0, "if_read");
        do_txn(1, 1, 32'h0000_0104, 32'h0000_00C1, 2'd0, 32'h0, 0, "mem_write");
        do_txn(1, 0, 32'h0000_0200, 32'h0, 2'd1, 32'hAAAA_80FF, 0, "mem_read_len1");
    endtask

    task automatic test_random();
        bit is_mem;
        for (int t = 0; t < 24; t++) begin
            is_mem = ($urandom_range(0, 2) != 0);
            do_txn(is_mem, is_mem ? 1'($urandom) : 1'b0, $urandom, $urandom, 2'($urandom),
                   $urandom, 1, $sformatf("rand%0d", t));
        end
    endtask

    task automatic test_arbitration();
        bit mem_av, if_av, ptr_mem, exp_w, got_w;
        int guard;
        do_reset();
        tx_ready = 1'b1; rx_valid = 1'b1; rx_data = 8'h5A;
        mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'h300; if_addr = 32'h400;
        @(negedge clk);
        if_req = 1'b1; mem_req = 1'b1; mem_av = 1; if_av = 1; ptr_mem = 1;
        for (int g = 0; g < 5; g++) begin
            guard = 0;
            while (!if_done && !mem_done && guard < 100) begin @(negedge clk); guard++; end
            checks++;
            if (guard >= 100) begin errors++; $display("FAIL arb_timeout grant=%0d got=none want=done", g); break; end
`ifdef MEM_ARB_RR_EN
            exp_w = mem_av & (!if_av | ptr_mem);
`else
            exp_w = mem_av;
`endif
            got_w = mem_done;
            if (got_w !== exp_w || (if_done && mem_done)) begin
                errors++; $display("FAIL arb_order grant=%0d got_mem=%b want_mem=%b", g, got_w, exp_w);
            end
            $display("txn arb grant=%0d winner=%s", g, got_w ? "mem" : "if");
            ptr_mem = !exp_w;
            if (got_w) begin mem_req = 1'b0; mem_av = 0; exp_mem = 32'h5A; end
            else begin if_req = 1'b0; if_av = 0; exp_if = 32'h5A5A_5A5A; end
            @(negedge clk);
            if (g < 3) begin
                if (got_w) begin mem_req = 1'b1; mem_av = 1; end
                else begin if_req = 1'b1; if_av = 1; end
            end
        end
        if_req = 1'b0; mem_req = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
        checks++;
        if (if_rdata !== exp_if || mem_rdata !== exp_mem) begin
            errors++; $display("FAIL arb_rdata got=%h/%h want=%h/%h", if_rdata, mem_rdata, exp_if, exp_mem);
        end
    endtask

    task automatic test_stall_reset();
        logic [7:0] got[$];
        logic [7:0] want[$] = '{8'hC0, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h03};
        int rxn = 0, guard = 0;
        bit stalled = 0, ok, seen_done = 0;
        tx_ready = 1'b1; rx_valid = 1'b0;
        @(negedge clk);
        if_addr = 32'h0000_1234; if_req = 1'b1;
        while (rxn < 2 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (if_done || mem_done) seen_done = 1;
            if (tx_valid && got.size() == 3 && !stalled) begin
                stalled = 1; tx_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    checks++;
                    if (tx_valid !== 1'b1 || tx_data !== 8'h00 || busy !== 1'b1) begin
                        errors++; $display("FAIL stall_hold cyc=%0d got=%b/%h want=1/00", k, tx_valid, tx_data);
                    end
                end
                tx_ready = 1'b1;
            end
            if (tx_valid && tx_ready) got.push_back(tx_data);
            rx_valid = 1'b1;
            rx_data  = (rxn == 0) ? 8'h78 : 8'h56;
            if (rx_ready) rxn++;
        end
        ok = (got.size() == want.size());
        for (int i = 0; i < got.size() && ok; i++) if (got[i] !== want[i]) ok = 0;
        checks++;
        if (!ok || guard >= 100) begin errors++; $display("FAIL stall_stream got=%p want=%p", got, want); end
        @(negedge clk);
        rst = 1'b1; if_req = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
        if (if_done || mem_done) seen_done = 1;
        @(negedge clk);
        rst = 1'b0;
        exp_if = '0; exp_mem = '0;
        checks++;
        if (busy !== 1'b0 || tx_valid !== 1'b0 || rx_ready !== 1'b0) begin
            errors++; $display("FAIL abort_idle got=%b%b%b want=000", busy, tx_valid, rx_ready);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (if_done || mem_done || busy) seen_done = 1;
        end
        checks++;
        if (seen_done) begin errors++; $display("FAIL abort_nodone got=1 want=0"); end
        checks++;
        if (if_rdata !== exp_if || mem_rdata !== exp_mem) begin
            errors++; $display("FAIL abort_rdata got=%h/%h want=0", if_rdata, mem_rdata);
        end
        $display("txn stall_reset bytes=%0d rx=%0d", got.size(), rxn);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_arbitration();
        test_stall_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_link_arbiter.md
Name: mem_link_arbiter

Overview:
- Shares the single UART memory link between the CPU instruction-fetch port (read-only) and the data port (read/write).
- Serialises each granted request into the link's byte protocol and, for reads, reassembles the little-endian reply.
- Sits between the core's fetch/LSU stages and the uart_comm byte interface that talks to the UART RAM.
- One transaction on the link at a time; no pipelining.

Parameters:
- ADDR_W, 32, request address width; fixed at 32 by the link protocol.
- IF_MASK, 3, byte-count-minus-one used for every fetch (4-byte fetch).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- if_req  in  1  fetch request, held until if_done
- if_addr  in  32  fetch byte address
- if_done  out  1  one-cycle completion pulse
- if_rdata  out  32  fetched word
- mem_req  in  1  data request, held until mem_done
- mem_we  in  1  1 = write, 0 = read
- mem_addr  in  32  data byte address
- mem_wdata  in  32  write data, little-endian
- mem_len  in  2  byte count minus one (0..3)
- mem_done  out  1  one-cycle completion pulse
- mem_rdata  out  32  read data, zero-extended
- tx_valid  out  1  byte offered to uart_comm
- tx_data  out  8  byte to send
- tx_ready  in  1  uart_comm accepts the byte (transfer = tx_valid & tx_ready)
- rx_valid  in  1  received byte available
- rx_data  in  8  received byte
- rx_ready  out  1  arbiter consumes the byte (transfer = rx_valid & rx_ready)
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; rdata registers 0; byte counter 0; priority pointer set to the data port.

FSM states: IDLE, HDR, WDATA, RECV, DONE.
- IDLE: pick the winner if any req is high.
  - Latch addr, we, mask (IF: we=0, mask=IF_MASK; data port: mem_len) and wdata.
  - Clear counter; go to HDR. The first tx_valid appears the following cycle.
- HDR: sends 7 bytes, counter 0..6:
  - byte 0: 0xC0 for read, 0x80 for write.
  - bytes 1..4: {1'b0, addr[6:0]}, {1'b0, addr[14:8]}, {1'b0, addr[22:16]}, {1'b0, addr[30:24]}.
  - byte 5: {4'b0, addr[31], addr[23], addr[15], addr[7]}.
  - byte 6: {6'b0, mask}.
  - After byte 6 transfers: go to WDATA for a write, RECV for a read.
- WDATA: sends mask+1 bytes {1'b0, wdata[8i+6:8i]} for i=0..mask, then the MSB byte {4'b0, wdata[31], wdata[23], wdata[15], wdata[7]}.
  - All four MSB bits are sent regardless of mask.
  - After the last transfer: go to DONE. Writes get no reply.
- RECV: rx_ready=1 only in this state. Byte i is stored to rdata[8i+7:8i], i=0..mask.
  - Bytes above mask are zeroed.
  - After byte number mask: update the winner's rdata register; go to DONE.
- DONE: the winner's done is high for exactly this cycle; then go to IDLE.
  - The requester drops req on the edge where it samples done=1, so IDLE never re-grants the same transaction.
- Handshakes:
  - tx_data and tx_valid stay stable while tx_ready=0.
  - The counter advances only on a transfer. With tx_ready held at 1, one byte is sent per cycle.
  - rx_valid outside RECV is ignored; the byte is left pending.
- Latency:
  - Write: 1 (grant) + 7 + mask+2 transfer cycles + 1 DONE.
  - Read: 1 + 7 + mask+1 rx transfers + 1.
- rdata: if_rdata and mem_rdata hold their value until the next read completion on that port; a write leaves mem_rdata unchanged.
- Request fields: latched at grant; changes while busy are ignored.
- Reset mid-transaction: abort immediately with no done pulse. The link partner must be reset with the same rst.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Undefined: fixed priority; the data port wins when both req are high.
- Defined: round-robin; after a grant the pointer moves to the other port, so when both ports request continuously the grants alternate.

Test Plan:
- Reset -> tx_valid=0, rx_ready=0, busy=0, if_rdata=mem_rdata=0, no done.
- IF read if_addr=0x00001234, tx_ready=1 -> tx bytes C0 34 12 00 00 00 03; rx 78 56 34 12 -> if_rdata=0x12345678, if_done high 1 cycle, total 13 cycles from grant.
- Data write mem_addr=0x104, mem_wdata=0x000000C1, mem_len=0 -> tx bytes 80 04 01 00 00 00 00 41 01, then mem_done; rx_ready stays 0 throughout.
- Data read mem_len=1 at 0x200, rx 0xFF 0x80 -> mem_rdata=0x000080FF.
- if_req and mem_req rise together, held and re-raised after each done:
  - Without MEM_ARB_RR_EN: order mem, if (mem wins).
  - With MEM_ARB_RR_EN: grants alternate mem, if, mem, if.
- tx_ready=0 for 5 cycles during HDR byte 3, then reset asserted in RECV after 2 rx bytes:
  - During the stall: tx_data held at 0x00 and counter frozen.
  - After the reset: returns to IDLE, no done pulse, busy=0.
